// File: rtl/rv32i_enc_pkg.sv
// Shared constants for the RV32I program encoder: symbolic op codes, base opcodes,
// funct fields and the encoder state enum.
package rv32i_enc_pkg;

    localparam logic [5:0] OP_ADD   = 6'd0;
    localparam logic [5:0] OP_SUB   = 6'd1;
    localparam logic [5:0] OP_SLL   = 6'd2;
    localparam logic [5:0] OP_SLT   = 6'd3;
    localparam logic [5:0] OP_SLTU  = 6'd4;
    localparam logic [5:0] OP_XOR   = 6'd5;
    localparam logic [5:0] OP_SRL   = 6'd6;
    localparam logic [5:0] OP_SRA   = 6'd7;
    localparam logic [5:0] OP_OR    = 6'd8;
    localparam logic [5:0] OP_AND   = 6'd9;
    localparam logic [5:0] OP_ADDI  = 6'd10;
    localparam logic [5:0] OP_SLLI  = 6'd11;
    localparam logic [5:0] OP_SLTI  = 6'd12;
    localparam logic [5:0] OP_SLTIU = 6'd13;
    localparam logic [5:0] OP_XORI  = 6'd14;
    localparam logic [5:0] OP_SRLI  = 6'd15;
    localparam logic [5:0] OP_SRAI  = 6'd16;
    localparam logic [5:0] OP_ORI   = 6'd17;
    localparam logic [5:0] OP_ANDI  = 6'd18;
    localparam logic [5:0] OP_LB    = 6'd19;
    localparam logic [5:0] OP_LH    = 6'd20;
    localparam logic [5:0] OP_LW    = 6'd21;
    localparam logic [5:0] OP_LBU   = 6'd22;
    localparam logic [5:0] OP_LHU   = 6'd23;
    localparam logic [5:0] OP_SB    = 6'd24;
    localparam logic [5:0] OP_SH    = 6'd25;
    localparam logic [5:0] OP_SW    = 6'd26;
    localparam logic [5:0] OP_BEQ   = 6'd27;
    localparam logic [5:0] OP_BNE   = 6'd28;
    localparam logic [5:0] OP_BLT   = 6'd29;
    localparam logic [5:0] OP_BGE   = 6'd30;
    localparam logic [5:0] OP_BLTU  = 6'd31;
    localparam logic [5:0] OP_BGEU  = 6'd32;
    localparam logic [5:0] OP_LUI   = 6'd33;
    localparam logic [5:0] OP_AUIPC = 6'd34;
    localparam logic [5:0] OP_JAL   = 6'd35;
    localparam logic [5:0] OP_JALR  = 6'd36;
    localparam logic [5:0] OP_LI    = 6'd37;

    localparam logic [6:0] OPC_OP     = 7'h33;
    localparam logic [6:0] OPC_OPIMM  = 7'h13;
    localparam logic [6:0] OPC_LOAD   = 7'h03;
    localparam logic [6:0] OPC_STORE  = 7'h23;
    localparam logic [6:0] OPC_BRANCH = 7'h63;
    localparam logic [6:0] OPC_LUI    = 7'h37;
    localparam logic [6:0] OPC_AUIPC  = 7'h17;
    localparam logic [6:0] OPC_JAL    = 7'h6F;
    localparam logic [6:0] OPC_JALR   = 7'h67;

    localparam logic [2:0] F3_ADD  = 3'd0;
    localparam logic [2:0] F3_SLL  = 3'd1;
    localparam logic [2:0] F3_SLT  = 3'd2;
    localparam logic [2:0] F3_SLTU = 3'd3;
    localparam logic [2:0] F3_XOR  = 3'd4;
    localparam logic [2:0] F3_SR   = 3'd5;
    localparam logic [2:0] F3_OR   = 3'd6;
    localparam logic [2:0] F3_AND  = 3'd7;
    localparam logic [2:0] F3_B    = 3'd0;
    localparam logic [2:0] F3_H    = 3'd1;
    localparam logic [2:0] F3_W    = 3'd2;
    localparam logic [2:0] F3_BU   = 3'd4;
    localparam logic [2:0] F3_HU   = 3'd5;
    localparam logic [2:0] F3_BEQ  = 3'd0;
    localparam logic [2:0] F3_BNE  = 3'd1;
    localparam logic [2:0] F3_BLT  = 3'd4;
    localparam logic [2:0] F3_BGE  = 3'd5;
    localparam logic [2:0] F3_BLTU = 3'd6;
    localparam logic [2:0] F3_BGEU = 3'd7;

    localparam logic [6:0] F7_BASE = 7'h00;
    localparam logic [6:0] F7_ALT  = 7'h20;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WR1  = 2'd1,
        ST_WR2  = 2'd2,
        ST_ERR  = 2'd3
    } enc_state_e;

endpackage

// File: rtl/rv32i_word_pack.sv
// Combinational field packer: maps one symbolic instruction to its machine word(s)
// and flags whether the operands are encodable.
module rv32i_word_pack
    import rv32i_enc_pkg::*;
(
    input  logic [5:0]  op,
    input  logic [4:0]  rd,
    input  logic [4:0]  rs1,
    input  logic [4:0]  rs2,
    input  logic [31:0] imm,
    output logic [31:0] word,
    output logic        range_ok,
    output logic        needs_two,
    output logic [31:0] second_word
);

    logic        fits12_s;
    logic        fits13_s;
    logic        fits21_s;
    logic        shamt_ok_s;
    logic [19:0] hi_s;
    logic [2:0]  f3_s;
    logic [6:0]  f7_s;
    logic        is_shift_s;

    assign fits12_s   = (imm[31:11] == 21'h000000) || (imm[31:11] == 21'h1FFFFF);
    assign fits13_s   = (imm[31:12] == 20'h00000)  || (imm[31:12] == 20'hFFFFF);
    assign fits21_s   = (imm[31:20] == 12'h000)    || (imm[31:20] == 12'hFFF);
    assign shamt_ok_s = (imm[31:5] == 27'h0000000);
    // Rounding the upper part compensates for the sign-extended low 12 bits of the ADDI.
    assign hi_s       = imm[31:12] + {19'd0, imm[11]};
    assign is_shift_s = (op == OP_SLLI) || (op == OP_SRLI) || (op == OP_SRAI);
    assign f7_s       = ((op == OP_SUB) || (op == OP_SRA) || (op == OP_SRAI)) ? F7_ALT : F7_BASE;

    // funct3 selection per op code
    always_comb begin
        f3_s = F3_ADD;
        case (op)
            OP_ADD, OP_SUB, OP_ADDI, OP_JALR: f3_s = F3_ADD;
            OP_SLL, OP_SLLI:                  f3_s = F3_SLL;
            OP_SLT, OP_SLTI:                  f3_s = F3_SLT;
            OP_SLTU, OP_SLTIU:                f3_s = F3_SLTU;
            OP_XOR, OP_XORI:                  f3_s = F3_XOR;
            OP_SRL, OP_SRA, OP_SRLI, OP_SRAI: f3_s = F3_SR;
            OP_OR, OP_ORI:                    f3_s = F3_OR;
            OP_AND, OP_ANDI:                  f3_s = F3_AND;
            OP_LB, OP_SB:                     f3_s = F3_B;
            OP_LH, OP_SH:                     f3_s = F3_H;
            OP_LW, OP_SW:                     f3_s = F3_W;
            OP_LBU:                           f3_s = F3_BU;
            OP_LHU:                           f3_s = F3_HU;
            OP_BEQ:                           f3_s = F3_BEQ;
            OP_BNE:                           f3_s = F3_BNE;
            OP_BLT:                           f3_s = F3_BLT;
            OP_BGE:                           f3_s = F3_BGE;
            OP_BLTU:                          f3_s = F3_BLTU;
            OP_BGEU:                          f3_s = F3_BGEU;
            default:                          f3_s = F3_ADD;
        endcase
    end

    // Field packing and range check per instruction class
    always_comb begin
        word        = 32'h0000_0000;
        range_ok    = 1'b0;
        needs_two   = 1'b0;
        second_word = 32'h0000_0000;
        if (op <= OP_AND) begin
            word     = {f7_s, rs2, rs1, f3_s, rd, OPC_OP};
            range_ok = 1'b1;
        end else if (op <= OP_ANDI) begin
            if (is_shift_s) begin
                word     = {f7_s, imm[4:0], rs1, f3_s, rd, OPC_OPIMM};
                range_ok = shamt_ok_s;
            end else begin
                word     = {imm[11:0], rs1, f3_s, rd, OPC_OPIMM};
                range_ok = fits12_s;
            end
        end else if (op <= OP_LHU) begin
            word     = {imm[11:0], rs1, f3_s, rd, OPC_LOAD};
            range_ok = fits12_s;
        end else if (op <= OP_SW) begin
            word     = {imm[11:5], rs2, rs1, f3_s, imm[4:0], OPC_STORE};
            range_ok = fits12_s;
        end else if (op <= OP_BGEU) begin
            word     = {imm[12], imm[10:5], rs2, rs1, f3_s, imm[4:1], imm[11], OPC_BRANCH};
            range_ok = fits13_s && !imm[0];
        end else if ((op == OP_LUI) || (op == OP_AUIPC)) begin
            word     = {imm[31:12], rd, (op == OP_LUI) ? OPC_LUI : OPC_AUIPC};
            range_ok = (imm[11:0] == 12'h000);
        end else if (op == OP_JAL) begin
            word     = {imm[20], imm[10:1], imm[11], imm[19:12], rd, OPC_JAL};
            range_ok = fits21_s && !imm[0];
        end else if (op == OP_JALR) begin
            word     = {imm[11:0], rs1, F3_ADD, rd, OPC_JALR};
            range_ok = fits12_s;
        end else if (op == OP_LI) begin
            range_ok = 1'b1;
            if (fits12_s) begin
                word = {imm[11:0], 5'd0, F3_ADD, rd, OPC_OPIMM};
            end else begin
                word        = {hi_s, rd, OPC_LUI};
                needs_two   = (imm[11:0] != 12'h000);
                second_word = {imm[11:0], rd, F3_ADD, rd, OPC_OPIMM};
            end
        end else begin
            range_ok = 1'b0;
        end
    end

endmodule

// File: rtl/instr_encoder_rv32i.sv
// Sequential RV32I encoder: accepts symbolic instructions and writes machine words
// to instruction memory at an auto-incrementing address.
module instr_encoder_rv32i
    import rv32i_enc_pkg::*;
#(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              enc_clr,
    input  logic              enc_valid,
    output logic              enc_ready,
    input  logic [5:0]        enc_op,
    input  logic [4:0]        enc_rd,
    input  logic [4:0]        enc_rs1,
    input  logic [4:0]        enc_rs2,
    input  logic [31:0]       enc_imm,
    output logic              enc_err,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic [ADDR_W:0]   word_count,
    output logic              full
);

    localparam logic [ADDR_W:0] DEPTH_V = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W:0] LAST_V  = DEPTH_V - {{ADDR_W{1'b0}}, 1'b1};
    localparam logic [ADDR_W:0] ONE_V   = {{ADDR_W{1'b0}}, 1'b1};

    enc_state_e        state_r;
    logic              two_r;
    logic [31:0]       second_r;
    logic [31:0]       word_s;
    logic              range_ok_s;
    logic              needs_two_s;
    logic [31:0]       second_s;
    logic              reject_s;
    logic [ADDR_W:0]   next_count_s;

    rv32i_word_pack u_pack (
        .op          (enc_op),
        .rd          (enc_rd),
        .rs1         (enc_rs1),
        .rs2         (enc_rs2),
        .imm         (enc_imm),
        .word        (word_s),
        .range_ok    (range_ok_s),
        .needs_two   (needs_two_s),
        .second_word (second_s)
    );

    assign enc_ready    = (state_r == ST_IDLE) && !full && !enc_clr && rst_n;
    // A two-word LI is refused when only the last slot remains.
    assign reject_s     = !range_ok_s || (needs_two_s && (word_count == LAST_V));
    assign next_count_s = word_count + ONE_V;
    assign mem_addr     = word_count[ADDR_W-1:0];

    // Encoder FSM, write pointer and registered memory-side outputs
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r    <= ST_IDLE;
            two_r      <= 1'b0;
            second_r   <= 32'h0000_0000;
            mem_we     <= 1'b0;
            mem_wdata  <= 32'h0000_0000;
            enc_err    <= 1'b0;
            word_count <= '0;
            full       <= 1'b0;
        end else if (enc_clr) begin
            state_r    <= ST_IDLE;
            two_r      <= 1'b0;
            mem_we     <= 1'b0;
            enc_err    <= 1'b0;
            word_count <= '0;
            full       <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (enc_valid && enc_ready) begin
                        if (reject_s) begin
                            state_r <= ST_ERR;
                            enc_err <= 1'b1;
                            mem_we  <= 1'b0;
                        end else begin
                            state_r   <= ST_WR1;
                            enc_err   <= 1'b0;
                            mem_we    <= 1'b1;
                            mem_wdata <= word_s;
                            two_r     <= needs_two_s;
                            second_r  <= second_s;
                        end
                    end else begin
                        mem_we  <= 1'b0;
                        enc_err <= 1'b0;
                    end
                end
                ST_WR1: begin
                    word_count <= next_count_s;
                    full       <= (next_count_s == DEPTH_V);
                    if (two_r) begin
                        state_r   <= ST_WR2;
                        mem_we    <= 1'b1;
                        mem_wdata <= second_r;
                    end else begin
                        state_r <= ST_IDLE;
                        mem_we  <= 1'b0;
                    end
                end
                ST_WR2: begin
                    word_count <= next_count_s;
                    full       <= (next_count_s == DEPTH_V);
                    state_r    <= ST_IDLE;
                    mem_we     <= 1'b0;
                    two_r      <= 1'b0;
                end
                ST_ERR: begin
                    state_r <= ST_IDLE;
                    enc_err <= 1'b0;
                    mem_we  <= 1'b0;
                end
                default: begin
                    state_r <= ST_IDLE;
                    enc_err <= 1'b0;
                    mem_we  <= 1'b0;
                end
            endcase
        end
    end

endmodule
